// File: rtl/updi_frame_tx.sv
// updi_frame_tx: buffers pre-formatted 12-bit UPDI frames and shifts them MSB-first onto the
// single-wire line with a fixed bit divider and idle guard time. Optional BREAK: UPDI_TX_BREAK_EN.
module updi_frame_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD_BITS = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [11:0]                   i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_trans_en,
`ifdef UPDI_TX_BREAK_EN
  input  logic                          i_break,
  output logic                          o_break_done,
`endif
  output logic                          o_tx,
  output logic                          o_tx_oe,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_frame_done
);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;
  localparam int CW        = $clog2(CLK_DIV);
  localparam int GUARD_CYC = GUARD_BITS * CLK_DIV;
  localparam int GW        = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  localparam logic [CW-1:0] CYC_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CYC_PRE    = CW'(CLK_DIV - 2);
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);

`ifdef UPDI_TX_BREAK_EN
  localparam int BRK_CYC = 26 * CLK_DIV;
  localparam int BW      = $clog2(BRK_CYC);
  localparam logic [BW-1:0] BRK_LOW_LAST = BW'(24 * CLK_DIV - 1);
  localparam logic [BW-1:0] BRK_PRE      = BW'(BRK_CYC - 2);
  localparam logic [BW-1:0] BRK_LAST     = BW'(BRK_CYC - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2
`ifdef UPDI_TX_BREAK_EN
    , ST_BREAK = 2'd3
`endif
  } state_t;

  state_t          state;
  logic [11:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [10:0]     shreg;
  logic [CW-1:0]   cyc_cnt;
  logic [3:0]      bit_idx;
  logic [GW-1:0]   guard_cnt;
  logic            push;
  logic            pop;
  logic            frame_end;
  logic            guard_end;
  logic            exit_pt;
  logic            brk_go;
  logic            shift_en;

  assign o_ready      = (count != LVL_FULL);
  assign o_fifo_level = count;
  assign o_busy       = (state != ST_IDLE);
  assign push         = i_valid & o_ready;

  // Every point where the line becomes free: IDLE itself, guard expiry, or frame end without guard.
  assign frame_end = (state == ST_SHIFT) && (bit_idx == 4'd11) && (cyc_cnt == CYC_LAST);
  assign guard_end = (state == ST_GUARD) && (guard_cnt == GUARD_LAST);
  assign exit_pt   = (state == ST_IDLE) || guard_end || (frame_end && (GUARD_BITS == 0));
  assign shift_en  = (state == ST_SHIFT) && (cyc_cnt == CYC_LAST) && (bit_idx != 4'd11);

`ifdef UPDI_TX_BREAK_EN
  logic          brk_pend;
  logic [BW-1:0] brk_cnt;
  assign brk_go = exit_pt & brk_pend;
`else
  assign brk_go = 1'b0;
`endif

  assign pop = exit_pt & ~brk_go & (count != '0) & i_trans_en;

  always_ff @(posedge i_clk) begin
    if (i_rstn && push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (pop) shreg <= mem[rd_ptr][10:0];
    else if (shift_en) shreg <= {shreg[9:0], 1'b0};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cyc_cnt      <= '0;
      bit_idx      <= '0;
      guard_cnt    <= '0;
      o_tx         <= 1'b1;
      o_tx_oe      <= 1'b0;
      o_frame_done <= 1'b0;
`ifdef UPDI_TX_BREAK_EN
      brk_pend     <= 1'b0;
      brk_cnt      <= '0;
      o_break_done <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
      o_frame_done <= (state == ST_SHIFT) && (bit_idx == 4'd11) && (cyc_cnt == CYC_PRE);
`ifdef UPDI_TX_BREAK_EN
      brk_pend     <= i_break | (brk_pend & ~brk_go);
      o_break_done <= (state == ST_BREAK) && (brk_cnt == BRK_PRE);
`endif
      if (exit_pt) begin
        cyc_cnt   <= '0;
        bit_idx   <= '0;
        guard_cnt <= '0;
`ifdef UPDI_TX_BREAK_EN
        brk_cnt   <= '0;
`endif
        if (pop) begin
          state   <= ST_SHIFT;
          o_tx    <= mem[rd_ptr][11];
          o_tx_oe <= 1'b1;
`ifdef UPDI_TX_BREAK_EN
        end else if (brk_go) begin
          state   <= ST_BREAK;
          o_tx    <= 1'b0;
          o_tx_oe <= 1'b1;
`endif
        end else begin
          state   <= ST_IDLE;
          o_tx    <= 1'b1;
          o_tx_oe <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_SHIFT: begin
            if (cyc_cnt == CYC_LAST) begin
              cyc_cnt <= '0;
              if (bit_idx == 4'd11) begin
                state     <= ST_GUARD;
                guard_cnt <= '0;
                o_tx      <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 4'd1;
                o_tx    <= shreg[10];
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
          ST_GUARD: guard_cnt <= guard_cnt + GW'(1);
`ifdef UPDI_TX_BREAK_EN
          ST_BREAK: begin
            brk_cnt <= brk_cnt + BW'(1);
            if (brk_cnt == BRK_LOW_LAST) o_tx <= 1'b1;
            if (brk_cnt == BRK_LAST) begin
              state   <= ST_IDLE;
              o_tx    <= 1'b1;
              o_tx_oe <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_updi_frame_tx.sv
// tb_updi_frame_tx: table vectors, directed corner sequences and randomized traffic against a
// line-timeline reference model for updi_frame_tx (CLK_DIV=4, FIFO_DEPTH=4, GUARD_BITS=2).
module tb_updi_frame_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int GUARD_BITS = 2;

  logic        clk;
  logic        rstn;
  logic [11:0] data;
  logic        valid;
  logic        ready;
  logic        trans_en;
  logic        tx;
  logic        oe;
  logic        busy;
  logic [2:0]  level;
  logic        done;
`ifdef UPDI_TX_BREAK_EN
  logic        brk;
  logic        brk_done;
`endif

  updi_frame_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GUARD_BITS(GUARD_BITS)) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_data(data),
    .i_valid(valid),
    .o_ready(ready),
    .i_trans_en(trans_en),
`ifdef UPDI_TX_BREAK_EN
    .i_break(brk),
    .o_break_done(brk_done),
`endif
    .o_tx(tx),
    .o_tx_oe(oe),
    .o_busy(busy),
    .o_fifo_level(level),
    .o_frame_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: queued frames plus a timeline of future line samples.
  typedef struct packed { logic tx; logic oe; logic done; } samp_t;
  logic [11:0] mfifo[$];
  samp_t       mline[$];
  samp_t       cur = '{1'b1, 1'b0, 1'b0};

  task automatic model_step(input logic r, input logic v, input logic [11:0] d, input logic en);
    logic        do_pop;
    logic        do_push;
    logic [11:0] f;
    if (!r) begin
      mfifo.delete();
      mline.delete();
      cur = '{1'b1, 1'b0, 1'b0};
      return;
    end
    do_pop  = (mline.size() == 0) && (mfifo.size() > 0) && en;
    do_push = v && (mfifo.size() < FIFO_DEPTH);
    if (do_pop) begin
      f = mfifo.pop_front();
      for (int b = 11; b >= 0; b--)
        for (int c = 0; c < CLK_DIV; c++)
          mline.push_back('{f[b], 1'b1, (b == 0) && (c == CLK_DIV - 1)});
      for (int g = 0; g < GUARD_BITS * CLK_DIV; g++) mline.push_back('{1'b1, 1'b1, 1'b0});
    end
    if (do_push) mfifo.push_back(d);
    if (mline.size() > 0) cur = mline.pop_front();
    else cur = '{1'b1, 1'b0, 1'b0};
  endtask

  task automatic cycle(input logic r, input logic v, input logic [11:0] d, input logic en);
    rstn = r; valid = v; data = d; trans_en = en;
    model_step(r, v, d, en);
    @(posedge clk);
    @(negedge clk);
    chk("tx", tx, cur.tx);
    chk("oe", oe, cur.oe);
    chk("busy", busy, cur.oe);
    chk("frame_done", done, cur.done);
    chk("level", level, mfifo.size());
    chk("ready", ready, mfifo.size() != FIFO_DEPTH);
  endtask

  typedef struct {
    logic r; logic v; logic [11:0] d; logic en;
    logic [2:0] lvl; logic rdy; logic etx; logic eoe;
  } vec_t;
  vec_t tbl[10];

  logic [11:0] synch;
  int          ndone;

  initial begin
    rstn = 1'b0; valid = 1'b0; data = '0; trans_en = 1'b0;
`ifdef UPDI_TX_BREAK_EN
    brk = 1'b0;
`endif
    tbl[0] = '{1'b0, 1'b0, 12'h000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 12'h123, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 12'h000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 12'h2AB, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 12'hA5C, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 12'h000, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 12'h3C3, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 12'hF0F, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 12'h555, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 12'h000, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].en);
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_ready", ready, tbl[i].rdy);
      chk("tbl_tx", tx, tbl[i].etx);
      chk("tbl_oe", oe, tbl[i].eoe);
    end

    // Full FIFO: the stalled frame is refused on the pop cycle, taken on the next.
    cycle(1'b1, 1'b1, 12'h777, 1'b1);
    chk("full_pop_level", level, 3);
    cycle(1'b1, 1'b1, 12'h777, 1'b1);
    chk("fifth_accept_level", level, 4);
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0, 12'h000, 1'b1);
      ndone += int'(done);
    end
    chk("five_frames_done", ndone, 5);
    chk("drain_level", level, 0);
    chk("drain_busy", busy, 0);

    // SYNCH frame waveform.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 12'h000, 1'b1);
    chk("rst_tx", tx, 1);
    chk("rst_oe", oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", ready, 1);
    synch = 12'h2AB;
    cycle(1'b1, 1'b1, synch, 1'b1);
    chk("synch_prelaunch_tx", tx, 1);
    for (int c = 1; c <= 57; c++) begin
      cycle(1'b1, 1'b0, 12'h000, 1'b1);
      chk("synch_tx", tx, (c <= 48) ? synch[11 - (c - 1) / 4] : 1'b1);
      chk("synch_oe", oe, c <= 56);
      chk("synch_done", done, c == 48);
    end

    // trans_en dropped during bit 5 of the first of two frames.
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    cycle(1'b1, 1'b1, 12'h1F3, 1'b1);
    cycle(1'b1, 1'b1, 12'h0E6, 1'b1);
    for (int c = 2; c <= 21; c++) cycle(1'b1, 1'b0, 12'h000, 1'b1);
    for (int c = 0; c < 50; c++) cycle(1'b1, 1'b0, 12'h000, 1'b0);
    chk("en_drop_busy", busy, 0);
    chk("en_drop_oe", oe, 0);
    chk("en_drop_level", level, 1);

    // Reset during bit 7.
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    cycle(1'b1, 1'b1, 12'h2AB, 1'b1);
    for (int c = 1; c <= 30; c++) cycle(1'b1, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    chk("midrst_tx", tx, 1);
    chk("midrst_oe", oe, 0);
    chk("midrst_level", level, 0);
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      cycle(1'b1, 1'b0, 12'h000, 1'b1);
      ndone += int'(done);
    end
    chk("midrst_no_done", ndone, 0);

    // Randomized traffic with varying push density and trans_en gating.
    for (int i = 0; i < 3000; i++) begin
      int rate;
      rate = (i / 500) % 3;
      cycle(($urandom_range(0, 399) != 0),
            (rate == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 40) == 0),
            12'($urandom),
            ($urandom_range(0, 9) != 0));
    end

`ifdef UPDI_TX_BREAK_EN
    // BREAK requested mid-frame with a second frame queued.
    rstn = 1'b0; valid = 1'b0; trans_en = 1'b1; brk = 1'b0;
    @(posedge clk); @(negedge clk);
    rstn = 1'b1; valid = 1'b1; data = 12'h2AB;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    valid = 1'b0;
    for (int c = 2; c <= 165; c++) begin
      brk = (c == 10);
      @(posedge clk); @(negedge clk);
      if (c >= 57 && c <= 160) begin
        chk("brk_tx", tx, (c <= 152) ? 1'b0 : 1'b1);
        chk("brk_oe", oe, 1);
      end
      if (c >= 49) chk("brk_done", brk_done, c == 160);
      if (c == 100) chk("brk_level", level, 1);
      if (c == 161) chk("brk_post_oe", oe, 0);
      if (c == 162) begin
        chk("brk_next_tx", tx, 0);
        chk("brk_next_oe", oe, 1);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
